// File: rtl/audio_pkg.sv
// Shared types for the tone sequencer: FSM states, widths and the
// note descriptor carried through the note FIFO.
package audio_pkg;

   localparam int SAMPLE_W = 16;
   localparam int PERIOD_W = 16;
   localparam int TICKS_W  = 16;

   localparam logic [SAMPLE_W-1:0] AMP_DEFAULT = 16'h3FFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2,
      S_GAP  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [PERIOD_W-1:0] period;
      logic [TICKS_W-1:0]  ticks;
   } note_desc_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO of note descriptors with flush.
// Ports: CLK, RST (sync, active high), flush, push/wdata, pop/rdata,
//        count, full, empty. rdata shows the head entry.
module note_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   flush,
   input  logic                   push,
   input  note_desc_t             wdata,
   input  logic                   pop,
   output note_desc_t             rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   note_desc_t     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tone_sequencer.sv
// Sequenced square-wave tone source: queues (period, ticks) notes and
// plays each one, followed by a silent gap, on the 16-bit sample output.
// Ports: CLK, RST (sync, active high), stop (flush), note_valid/ready,
//        note_period, note_ticks, fifo_count, busy, done_pulse, data.
module tone_sequencer
   import audio_pkg::*;
#(
   parameter int                  DEPTH     = 8,
   parameter int                  TICK_DIV  = 50000,
   parameter int                  GAP_TICKS = 1,
   parameter logic [SAMPLE_W-1:0] AMP       = AMP_DEFAULT
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   stop,
   input  logic                   note_valid,
   output logic                   note_ready,
   input  logic [PERIOD_W-1:0]    note_period,
   input  logic [TICKS_W-1:0]     note_ticks,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy,
   output logic                   done_pulse,
   output logic [SAMPLE_W-1:0]    data
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   seq_state_t           state_q, state_d;
   logic [PERIOD_W-1:0]  per_q, per_d;
   logic [PERIOD_W-1:0]  phase_q, phase_d;
   logic [PERIOD_W:0]    phase_inc;
   logic [TICKS_W-1:0]   ticks_q, ticks_d;
   logic [PRE_W-1:0]     pre_q, pre_d;
   logic [SAMPLE_W-1:0]  data_d;
   logic                 wrap;
   logic                 fin;
   logic                 pop;
   logic                 push;
   logic                 full;
   logic                 empty;
   note_desc_t           wdesc;
   note_desc_t           head;

   assign note_ready = !full && !stop && !RST;
   assign push       = note_valid && note_ready;
   assign wdesc      = '{period: note_period, ticks: note_ticks};
   assign busy       = (state_q != S_IDLE);

   note_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .flush (stop),
      .push  (push),
      .wdata (wdesc),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   // One prescaler/ticks pair times both PLAY and GAP.
   assign wrap      = (pre_q == PRE_LAST);
   assign fin       = wrap && (ticks_q == TICKS_W'(1));
   assign phase_inc = {1'b0, phase_q} + 1'b1;

   always_comb begin
      state_d    = state_q;
      per_d      = per_q;
      phase_d    = phase_q;
      ticks_d    = ticks_q;
      pre_d      = pre_q;
      pop        = 1'b0;
      done_pulse = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            phase_d = '0;
            pre_d   = '0;
            if (!empty) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            pop     = 1'b1;
            per_d   = head.period;
            ticks_d = head.ticks;
            phase_d = '0;
            pre_d   = '0;
            state_d = (head.ticks == '0) ? S_IDLE : S_PLAY;
         end
         S_PLAY: begin
            pre_d = wrap ? '0 : pre_q + 1'b1;
            if (wrap) begin
               ticks_d = ticks_q - 1'b1;
            end
            // Wrapping at >= keeps the phase bounded for rests (P<2).
            if (phase_inc >= {1'b0, per_q}) begin
               phase_d = '0;
            end else begin
               phase_d = phase_inc[PERIOD_W-1:0];
            end
            if (fin) begin
               done_pulse = 1'b1;
               phase_d    = '0;
               pre_d      = '0;
               if (GAP_TICKS != 0) begin
                  state_d = S_GAP;
                  ticks_d = TICKS_W'(GAP_TICKS);
               end else begin
                  state_d = S_IDLE;
                  ticks_d = '0;
               end
            end
         end
         S_GAP: begin
            pre_d = wrap ? '0 : pre_q + 1'b1;
            if (wrap) begin
               ticks_d = ticks_q - 1'b1;
            end
            if (fin) begin
               state_d = S_IDLE;
               pre_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (stop) begin
         state_d    = S_IDLE;
         per_d      = '0;
         phase_d    = '0;
         ticks_d    = '0;
         pre_d      = '0;
         pop        = 1'b0;
         done_pulse = 1'b0;
      end
   end

   // data is registered, so it is computed from the phase of the
   // cycle about to start; that makes PLAY cycle 0 already high.
   always_comb begin
      data_d = '0;
      if (state_d == S_PLAY && per_d >= PERIOD_W'(2) &&
          phase_d < (per_d >> 1)) begin
         data_d = AMP;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         per_q   <= '0;
         phase_q <= '0;
         ticks_q <= '0;
         pre_q   <= '0;
         data    <= '0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         phase_q <= phase_d;
         ticks_q <= ticks_d;
         pre_q   <= pre_d;
         data    <= data_d;
      end
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer
// (TICK_DIV=4, GAP_TICKS=1, DEPTH=8).
module tb_tone_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        stop = 1'b0;
   logic        note_valid = 1'b0;
   logic        note_ready;
   logic [15:0] note_period = '0;
   logic [15:0] note_ticks = '0;
   logic [3:0]  fifo_count;
   logic        busy;
   logic        done_pulse;
   logic [15:0] data;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [15:0] A = 16'h3FFF;

   tone_sequencer #(
      .DEPTH     (8),
      .TICK_DIV  (4),
      .GAP_TICKS (1),
      .AMP       (16'h3FFF)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .stop        (stop),
      .note_valid  (note_valid),
      .note_ready  (note_ready),
      .note_period (note_period),
      .note_ticks  (note_ticks),
      .fifo_count  (fifo_count),
      .busy        (busy),
      .done_pulse  (done_pulse),
      .data        (data)
   );

   always #5 CLK = ~CLK;

   // Presents one note for one cycle; returns on the negedge after
   // the accepting posedge.
   task automatic push_one(input logic [15:0] p, input logic [15:0] t);
      @(negedge CLK);
      note_valid  = 1'b1;
      note_period = p;
      note_ticks  = t;
      @(negedge CLK);
      note_valid  = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      n_checks++;
      if (data !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_data got %h want 0000", data);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      n_checks++;
      if (fifo_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_count got %0d want 0", fifo_count);
      end
      n_checks++;
      if (done_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_done got %b want 0", done_pulse);
      end
      n_checks++;
      if (note_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready got %b want 0", note_ready);
      end
      RST = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (note_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset got %b want 1", note_ready);
      end
   endtask

   task automatic test_even_period();
      logic [15:0] exp [8];
      exp = '{A, A, 16'h0, 16'h0, A, A, 16'h0, 16'h0};
      push_one(16'd4, 16'd2);
      n_checks++;
      if (busy !== 1'b0 || fifo_count !== 4'd1) begin
         n_fail++;
         $display("FAIL p4_queued busy %b cnt %0d want 0 1",
                  busy, fifo_count);
      end
      @(negedge CLK);
      n_checks++;
      if (busy !== 1'b1 || data !== 16'h0) begin
         n_fail++;
         $display("FAIL p4_load busy %b data %h want 1 0000",
                  busy, data);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         n_checks++;
         if (data !== exp[k] || done_pulse !== (k == 7)) begin
            n_fail++;
            $display("FAIL p4_play k=%0d data %h done %b want %h %b",
                     k, data, done_pulse, exp[k], (k == 7));
         end
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         n_checks++;
         if (data !== 16'h0 || busy !== 1'b1 || done_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL p4_gap k=%0d data %h busy %b done %b",
                     k, data, busy, done_pulse);
         end
      end
      @(negedge CLK);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL p4_idle busy %b want 0", busy);
      end
   endtask

   task automatic test_odd_period();
      logic [15:0] exp [8];
      exp = '{A, A, 16'h0, 16'h0, 16'h0, A, A, 16'h0};
      push_one(16'd5, 16'd2);
      @(negedge CLK);
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         n_checks++;
         if (data !== exp[k]) begin
            n_fail++;
            $display("FAIL p5_play k=%0d data %h want %h",
                     k, data, exp[k]);
         end
      end
      repeat (6) @(negedge CLK);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL p5_idle busy %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge CLK);
      note_valid  = 1'b1;
      note_period = 16'd2;
      note_ticks  = 16'd1;
      @(negedge CLK);
      note_period = 16'd2;
      note_ticks  = 16'd1;
      @(negedge CLK);
      note_valid = 1'b0;
      // now at first LOAD; PLAY A 4 cycles, GAP 4, IDLE, LOAD, PLAY B
      repeat (9) @(negedge CLK);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle busy %b want 0", busy);
      end
      @(negedge CLK);
      n_checks++;
      if (busy !== 1'b1 || data !== 16'h0) begin
         n_fail++;
         $display("FAIL b2b_load busy %b data %h want 1 0000",
                  busy, data);
      end
      @(negedge CLK);
      n_checks++;
      if (data !== A) begin
         n_fail++;
         $display("FAIL b2b_play data %h want %h", data, A);
      end
      repeat (10) @(negedge CLK);
   endtask

   task automatic test_fifo_full();
      int c;
      push_one(16'd2, 16'd100);
      repeat (2) @(negedge CLK);
      n_checks++;
      if (fifo_count !== 4'd0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL full_start cnt %0d busy %b want 0 1",
                  fifo_count, busy);
      end
      note_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         note_period = 16'd2;
         note_ticks  = 16'd1;
         #1;
         n_checks++;
         if (note_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_fill i=%0d ready %b want 1", i, note_ready);
         end
         @(negedge CLK);
      end
      #1;
      n_checks++;
      if (fifo_count !== 4'd8 || note_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_at8 cnt %0d ready %b want 8 0",
                  fifo_count, note_ready);
      end
      @(negedge CLK);
      note_valid = 1'b0;
      n_checks++;
      if (fifo_count !== 4'd8) begin
         n_fail++;
         $display("FAIL full_ninth cnt %0d want 8", fifo_count);
      end
      c = 0;
      while (fifo_count !== 4'd7 && c < 500) begin
         @(negedge CLK);
         c++;
      end
      n_checks++;
      if (fifo_count !== 4'd7 || note_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_after_pop cnt %0d ready %b want 7 1",
                  fifo_count, note_ready);
      end
      stop = 1'b1;
      @(negedge CLK);
      stop = 1'b0;
      n_checks++;
      if (fifo_count !== 4'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_flush cnt %0d busy %b want 0 0",
                  fifo_count, busy);
      end
   endtask

   task automatic test_rest_and_discard();
      int dones;
      int loud;
      int busy_lo;
      dones   = 0;
      loud    = 0;
      busy_lo = 0;
      @(negedge CLK);
      note_valid  = 1'b1;
      note_period = 16'd0;
      note_ticks  = 16'd2;
      @(negedge CLK);
      note_period = 16'd4;
      note_ticks  = 16'd0;
      @(negedge CLK);
      note_valid = 1'b0;
      // from first LOAD: 8 PLAY, 4 GAP, IDLE, LOAD(T=0), IDLE
      for (int k = 0; k < 16; k++) begin
         if (done_pulse === 1'b1) dones++;
         if (data !== 16'h0) loud++;
         if (k >= 1 && k <= 8 && busy !== 1'b1) busy_lo++;
         @(negedge CLK);
      end
      n_checks++;
      if (dones != 1) begin
         n_fail++;
         $display("FAIL rest_done got %0d pulses want 1", dones);
      end
      n_checks++;
      if (loud != 0) begin
         n_fail++;
         $display("FAIL rest_data got %0d loud cycles want 0", loud);
      end
      n_checks++;
      if (busy_lo != 0) begin
         n_fail++;
         $display("FAIL rest_busy got %0d idle cycles want 0", busy_lo);
      end
      n_checks++;
      if (busy !== 1'b0 || fifo_count !== 4'd0) begin
         n_fail++;
         $display("FAIL discard_end busy %b cnt %0d want 0 0",
                  busy, fifo_count);
      end
   endtask

   task automatic test_stop();
      int bad;
      bad = 0;
      push_one(16'd4, 16'd10);
      repeat (2) @(negedge CLK);
      note_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         note_period = 16'd4;
         note_ticks  = 16'd1;
         @(negedge CLK);
      end
      n_checks++;
      if (fifo_count !== 4'd3 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stop_pre cnt %0d busy %b want 3 1",
                  fifo_count, busy);
      end
      stop = 1'b1;
      #1;
      n_checks++;
      if (note_ready !== 1'b0 || done_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_ready ready %b done %b want 0 0",
                  note_ready, done_pulse);
      end
      @(negedge CLK);
      stop       = 1'b0;
      note_valid = 1'b0;
      n_checks++;
      if (data !== 16'h0 || fifo_count !== 4'd0 ||
          busy !== 1'b0 || done_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_after data %h cnt %0d busy %b done %b",
                  data, fifo_count, busy, done_pulse);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (busy !== 1'b0 || fifo_count !== 4'd0 || data !== 16'h0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL stop_quiet got %0d active cycles want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_even_period();
      test_odd_period();
      test_back_to_back();
      test_fifo_full();
      test_rest_and_discard();
      test_stop();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Plays a queue of square-wave notes on the audio peripheral's 16-bit sample output.
- Software or a bus bridge pushes (period, duration) note descriptors into an internal FIFO.
- A state machine pops each descriptor and generates a square wave of the programmed period for the programmed duration, then inserts a fixed silent gap.
- Replaces the fixed-period oscillator with a programmable, sequenced source feeding the audio output path.

Parameters:
DEPTH, 8, note FIFO depth (power of 2, >=2)
TICK_DIV, 50000, CLK cycles per duration tick (1 ms at 50 MHz)
GAP_TICKS, 1, silent ticks inserted after each note (0 = no gap)
AMP, 16'h3FFF, sample value driven during the high half-period

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
stop  in  1  synchronous flush: empties FIFO, aborts current note
note_valid  in  1  descriptor present
note_ready  out  1  FIFO can accept; push when note_valid && note_ready
note_period  in  16  full square period in CLK cycles; 0 or 1 = rest (silence)
note_ticks  in  16  duration in ticks; 0 = note discarded
fifo_count  out  $clog2(DEPTH)+1  descriptors queued
busy  out  1  high in LOAD, PLAY, GAP
done_pulse  out  1  one-cycle pulse when a note's PLAY phase completes
data  out  16  audio sample, registered

Behaviour:
- Reset (RST high at an edge): FIFO empty, fifo_count=0, FSM=IDLE, data=0, busy=0, done_pulse=0, all counters 0. note_ready is combinational: (fifo_count<DEPTH) && !stop && !RST.
- Priority: RST > stop > normal operation.
- stop: at the next edge, FIFO is flushed, FSM=IDLE, data=0, no done_pulse. Any push presented in the same cycle is dropped because note_ready=0.
- FIFO: push and pop in the same cycle leave the count unchanged. No push is possible when full, even if a pop occurs that cycle.
- FSM states: IDLE, LOAD, PLAY, GAP.
- IDLE: data=0, busy=0. If fifo_count!=0, go to LOAD.
- LOAD (1 cycle): pop head and latch period P and ticks T.
  - T==0: return to IDLE with no done_pulse.
  - Otherwise: go to PLAY with phase and prescaler counters cleared.
- PLAY lasts exactly T*TICK_DIV cycles.
  - In PLAY cycle k (k=0 first): data=AMP if P>=2 and (k mod P) < (P>>1), else 0.
  - Odd P: high for floor(P/2) cycles, low for ceil(P/2).
  - Prescaler wraps at TICK_DIV-1; the remaining-ticks counter decrements on each wrap.
  - On the final wrap: assert done_pulse for one cycle, then go to GAP (GAP_TICKS>0) or IDLE (GAP_TICKS==0).
- GAP: data=0 for GAP_TICKS*TICK_DIV cycles, then go to IDLE.
- Latency:
  - Push accepted at edge t into an empty FIFO while IDLE → LOAD at t+1 → first PLAY cycle at t+2.
  - Back-to-back notes have IDLE+LOAD overhead of 2 cycles after GAP.
- Counters are 16 bits for phase, prescaler (≥$clog2(TICK_DIV) bits) and ticks, with no overflow: P ≤ 65535 and T ≤ 65535 fit.

Decomposition:
- Package audio_pkg: FSM state enum, SAMPLE_W=16, PERIOD_W=16, TICKS_W=16, AMP_DEFAULT, descriptor struct {period, ticks}.
- Sub-module note_fifo: synchronous FIFO of descriptors with push, pop, flush, count, full and empty.
- The FSM, counters and sample generation stay in tone_sequencer.

Test Plan (TICK_DIV=4, GAP_TICKS=1, DEPTH=8):
1. RST high 2 cycles → data=0, busy=0, fifo_count=0, done_pulse=0; note_ready=1 the cycle after RST drops.
2. Push P=4, T=2 → 8 PLAY cycles data=3FFF,3FFF,0,0,3FFF,3FFF,0,0; done_pulse on the last of these; then 4 cycles data=0 with busy=1; then busy=0.
3. Push P=5, T=2 → data=3FFF,3FFF,0,0,0,3FFF,3FFF,0 over 8 cycles.
4. Push 9 notes back-to-back while stalled in a long note (P=2, T=100) → fifo_count reaches 8, note_ready=0, 9th not accepted; after the next pop, note_ready=1.
5. Push P=0, T=2 then P=4, T=0 → 8 cycles data=0 with busy=1 and one done_pulse; second note discarded (no done_pulse, no PLAY).
6. Three queued and one playing, assert stop 1 cycle mid-PLAY → next cycle data=0, fifo_count=0, busy=0, no done_pulse; simultaneous note_valid ignored.
